// File: rtl/ps2_letter_receiver_pkg.sv
// Shared scan-code, ASCII and state definitions for the PS/2 letter front end.
// Pure declarations; no latency and no flow control.
package ps2_letter_receiver_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

  localparam logic [7:0] ORD_A = 8'h41, ORD_B = 8'h42, ORD_C = 8'h43, ORD_D = 8'h44;
  localparam logic [7:0] ORD_E = 8'h45, ORD_F = 8'h46, ORD_G = 8'h47, ORD_H = 8'h48;
  localparam logic [7:0] ORD_I = 8'h49, ORD_J = 8'h4A, ORD_K = 8'h4B, ORD_L = 8'h4C;
  localparam logic [7:0] ORD_M = 8'h4D, ORD_N = 8'h4E, ORD_O = 8'h4F, ORD_P = 8'h50;
  localparam logic [7:0] ORD_Q = 8'h51, ORD_R = 8'h52, ORD_S = 8'h53, ORD_T = 8'h54;
  localparam logic [7:0] ORD_U = 8'h55, ORD_V = 8'h56, ORD_W = 8'h57, ORD_X = 8'h58;
  localparam logic [7:0] ORD_Y = 8'h59, ORD_Z = 8'h5A;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] ascii;
  } letter_t;

  function automatic letter_t scan_to_letter(input logic [7:0] code);
    letter_t l;
    l.vld = 1'b1;
    case (code)
      SC_A: l.ascii = ORD_A;
      SC_B: l.ascii = ORD_B;
      SC_C: l.ascii = ORD_C;
      SC_D: l.ascii = ORD_D;
      SC_E: l.ascii = ORD_E;
      SC_F: l.ascii = ORD_F;
      SC_G: l.ascii = ORD_G;
      SC_H: l.ascii = ORD_H;
      SC_I: l.ascii = ORD_I;
      SC_J: l.ascii = ORD_J;
      SC_K: l.ascii = ORD_K;
      SC_L: l.ascii = ORD_L;
      SC_M: l.ascii = ORD_M;
      SC_N: l.ascii = ORD_N;
      SC_O: l.ascii = ORD_O;
      SC_P: l.ascii = ORD_P;
      SC_Q: l.ascii = ORD_Q;
      SC_R: l.ascii = ORD_R;
      SC_S: l.ascii = ORD_S;
      SC_T: l.ascii = ORD_T;
      SC_U: l.ascii = ORD_U;
      SC_V: l.ascii = ORD_V;
      SC_W: l.ascii = ORD_W;
      SC_X: l.ascii = ORD_X;
      SC_Y: l.ascii = ORD_Y;
      SC_Z: l.ascii = ORD_Z;
      default: begin
        l.vld   = 1'b0;
        l.ascii = 8'h00;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ps2_letter_receiver_if.sv
// Keyboard lines in, Bombe-facing character/key outputs; combinational wiring only.
// No flow control: the Bombe samples char_out/key_press as levels.
interface ps2_letter_receiver_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] char_out;
  logic       key_press;
  logic       frame_err;

  modport master (output ps2_clk, ps2_dat, input char_out, key_press, frame_err);
  modport slave  (input ps2_clk, ps2_dat, output char_out, key_press, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 synchronizer, falling-edge detect, 11-bit frame FSM and timeout.
// byte_valid/frame_err one cycle after the stop-bit edge; no backpressure.
module ps2_frame_rx
  import ps2_letter_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_cur, clk_prev, dat_cur;
  logic          fall;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [CW-1:0] idle_cnt;

  // Idle line level is high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_cur  <= 1'b1;
      clk_prev <= 1'b1;
      dat_cur  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_cur  <= clk_sync[1];
      clk_prev <= clk_cur;
      dat_cur  <= dat_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_cur;
  assign rx_byte = shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || state == RX_IDLE) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end

      // An edge arriving on the boundary cycle wins over the timeout.
      if (!fall && state != RX_IDLE && idle_cnt == CW'(TIMEOUT_CYCLES)) begin
        state     <= RX_IDLE;
        idle_cnt  <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_cur) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shift   <= {dat_cur, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= dat_cur;
            state   <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_cur && (^{shift, par_bit})) byte_valid <= 1'b1;
            else                                frame_err  <= 1'b1;
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_letter_receiver.sv
// Scan-code set 2 letter decoder: make/break/extended handling into char_out/key_press.
// Outputs update two cycles after the stop-bit edge; no backpressure.
module ps2_letter_receiver
  import ps2_letter_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_letter_receiver_if.slave bus
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  letter_t    letter;
  dec_state_t dec_state;
  logic [7:0] held_code;
  logic [7:0] char_q;
  logic       key_q;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_dat    (bus.ps2_dat),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (rx_err)
  );

  assign letter = scan_to_letter(rx_byte);

  // Bad frames never produce byte_valid, so a pending break survives them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_state <= DEC_NORM;
      held_code <= 8'h00;
      char_q    <= 8'h00;
      key_q     <= 1'b0;
    end else if (byte_valid) begin
      case (dec_state)
        DEC_NORM: begin
          if (rx_byte == SC_EXT) begin
            dec_state <= DEC_EXT;
          end else if (rx_byte == SC_BREAK) begin
            dec_state <= DEC_BRK;
          end else if (letter.vld && !key_q) begin
            char_q    <= letter.ascii;
            held_code <= rx_byte;
            key_q     <= 1'b1;
          end
        end
        DEC_BRK: begin
          if (rx_byte == held_code && key_q) key_q <= 1'b0;
          dec_state <= DEC_NORM;
        end
        DEC_EXT: begin
          dec_state <= (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_NORM;
        end
        DEC_EXT_BRK: dec_state <= DEC_NORM;
        default:     dec_state <= DEC_NORM;
      endcase
    end
  end

  assign bus.char_out  = char_q;
  assign bus.key_press = key_q;
  assign bus.frame_err = rx_err;

endmodule
